// File: rtl/open_drain_line.sv
// Open-drain line controller: pulls a wired-OR line low on request, senses it through a
// synchronizer and glitch filter, and (with OPEN_DRAIN_STUCK_EN defined) flags a line that fails to rise.
module open_drain_line #(
  parameter int FILTER       = 3,
  parameter int RISE_TIMEOUT = 16
) (
  input  logic CLK,
  input  logic _RST,
  input  logic ASSERT_REQ,
  input  logic CLR_STUCK,
  inout  wire  O,
  output logic LINE,
  output logic FALL,
  output logic RISE,
  output logic EXT,
  output logic STUCK
);

  localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int TW = $clog2(RISE_TIMEOUT + 1);

  if (FILTER < 1 || RISE_TIMEOUT <= FILTER + 2) begin : g_param_check
    $error("open_drain_line: need FILTER >= 1 and RISE_TIMEOUT > FILTER + 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_RELEASE,
    S_EXTLOW
  } state_e;

  state_e        state_q, state_d;
  logic          drive_q, drive_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          line_q, line_d;
  logic [FW-1:0] filt_q, filt_d;
  logic          fall_q, fall_d;
  logic          rise_q, rise_d;
  logic          stuck_q;
  logic          stuck_set;
  logic          to_expired;

  // Never drive high: the external pull-up owns the released level.
  assign O = drive_q ? 1'b0 : 1'bz;

  always_comb begin
    sync1_d = O;
    sync2_d = sync1_q;
    line_d  = line_q;
    filt_d  = '0;
    fall_d  = 1'b0;
    rise_d  = 1'b0;
    if (sync2_q != line_q) begin
      if (filt_q == FW'(FILTER - 1)) begin
        line_d = sync2_q;
        fall_d = ~sync2_q;
        rise_d = sync2_q;
      end else begin
        filt_d = filt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    stuck_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ASSERT_REQ)   state_d = S_DRIVE;
        else if (!line_q) state_d = S_EXTLOW;
      end
      S_DRIVE: begin
        if (!ASSERT_REQ) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (ASSERT_REQ)  state_d = S_DRIVE;
        else if (line_q) state_d = S_IDLE;
        else if (to_expired) begin
          state_d   = S_EXTLOW;
          stuck_set = 1'b1;
        end
      end
      S_EXTLOW: begin
        if (ASSERT_REQ)  state_d = S_DRIVE;
        else if (line_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign drive_d = (state_d == S_DRIVE);

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state_q <= S_IDLE;
      drive_q <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      line_q  <= 1'b1;
      filt_q  <= '0;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drive_q <= drive_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      line_q  <= line_d;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
      rise_q  <= rise_d;
    end
  end

`ifdef OPEN_DRAIN_STUCK_EN
  logic [TW-1:0] to_q, to_d;
  logic          stuck_d;

  // Cleared every DRIVE cycle so RELEASE always starts from zero; saturates at the limit.
  always_comb begin
    to_d = to_q;
    if (state_q == S_DRIVE) begin
      to_d = '0;
    end else if (state_q == S_RELEASE && to_q != TW'(RISE_TIMEOUT)) begin
      to_d = to_q + 1'b1;
    end
  end

  assign to_expired = (to_d == TW'(RISE_TIMEOUT)) && !line_q;

  always_comb begin
    stuck_d = stuck_q;
    if (stuck_set)      stuck_d = 1'b1;
    else if (CLR_STUCK) stuck_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      to_q    <= '0;
      stuck_q <= 1'b0;
    end else begin
      to_q    <= to_d;
      stuck_q <= stuck_d;
    end
  end
`else
  logic unused_stuck_path;
  assign to_expired        = 1'b0;
  assign stuck_q           = 1'b0;
  assign unused_stuck_path = CLR_STUCK ^ stuck_set;
`endif

  assign LINE  = line_q;
  assign FALL  = fall_q;
  assign RISE  = rise_q;
  assign EXT   = (state_q == S_EXTLOW);
  assign STUCK = stuck_q;

endmodule

// File: tb/tb_open_drain_line.sv
// Bench for open_drain_line: directed scenarios plus randomized traffic checked every cycle
// against a sample-history reference model; honours OPEN_DRAIN_STUCK_EN like the design.
module tb_open_drain_line;

  localparam int FILTER       = 3;
  localparam int RISE_TIMEOUT = 16;

  localparam int M_IDLE    = 0;
  localparam int M_DRIVE   = 1;
  localparam int M_RELEASE = 2;
  localparam int M_EXTLOW  = 3;

`ifdef OPEN_DRAIN_STUCK_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  logic clr = 1'b0;
  logic ext_low = 1'b0;
  wire  o_net;
  logic LINE, FALL, RISE, EXT, STUCK;

  int tests = 0;
  int fails = 0;

  assign o_net = ext_low ? 1'b0 : 1'bz;
  pullup (o_net);

  open_drain_line #(.FILTER(FILTER), .RISE_TIMEOUT(RISE_TIMEOUT)) dut (
    .CLK(clk), ._RST(rst_n), .ASSERT_REQ(req), .CLR_STUCK(clr), .O(o_net),
    .LINE(LINE), .FALL(FALL), .RISE(RISE), .EXT(EXT), .STUCK(STUCK)
  );

  always #5 clk = ~clk;

  // Reference model: pin history per edge; LINE flips once the FILTER most recent
  // synchronized samples (two edges old and older) all disagree with it.
  bit hist[$];
  int m_state, m_edge, m_rel_edge;
  bit m_line, m_fall, m_rise, m_stuck, m_drive;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < FILTER + 2; i++) hist.push_back(1'b1);
    m_state = M_IDLE; m_edge = 0; m_rel_edge = 0;
    m_line = 1'b1; m_fall = 1'b0; m_rise = 1'b0; m_stuck = 1'b0; m_drive = 1'b0;
  endfunction

  function automatic void model_step();
    bit pin, all_differ, old_line, set_stuck;
    pin = !(m_drive || ext_low);
    hist.push_back(pin);
    if (hist.size() > 64) void'(hist.pop_front());
    old_line = m_line;
    set_stuck = 1'b0;
    case (m_state)
      M_IDLE:    if (req) m_state = M_DRIVE; else if (!old_line) m_state = M_EXTLOW;
      M_DRIVE:   if (!req) begin m_state = M_RELEASE; m_rel_edge = m_edge; end
      M_RELEASE: if (req) m_state = M_DRIVE;
                 else if (old_line) m_state = M_IDLE;
                 else if (STUCK_EN && (m_edge - m_rel_edge) >= RISE_TIMEOUT) begin
                   m_state = M_EXTLOW; set_stuck = 1'b1;
                 end
      default:   if (req) m_state = M_DRIVE; else if (old_line) m_state = M_IDLE;
    endcase
    if (set_stuck) m_stuck = 1'b1;
    else if (clr && STUCK_EN) m_stuck = 1'b0;
    m_drive = (m_state == M_DRIVE);
    all_differ = 1'b1;
    for (int i = 0; i < FILTER; i++)
      if (hist[hist.size() - 3 - i] == old_line) all_differ = 1'b0;
    if (all_differ) m_line = !old_line;
    m_fall = old_line && !m_line;
    m_rise = !old_line && m_line;
    m_edge++;
  endfunction

  // One clock: advance the model with the DUT, then compare every output mid-cycle.
  task automatic tick();
    logic [5:0] act, exp;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    act = {LINE, FALL, RISE, EXT, STUCK, o_net};
    exp = {m_line, m_fall, m_rise, (m_state == M_EXTLOW), m_stuck, !(m_drive || ext_low)};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL scoreboard t=%0t {LINE,FALL,RISE,EXT,STUCK,O} got %b want %b", $time, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; clr = 1'b0; ext_low = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    tests++; if (o_net !== 1'b1) begin fails++; $display("FAIL reset_o got %b want 1", o_net); end
    tests++; if (LINE !== 1'b1) begin fails++; $display("FAIL reset_line got %b want 1", LINE); end
    tests++;
    if ({FALL, RISE, EXT, STUCK} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags got %b want 0000", {FALL, RISE, EXT, STUCK});
    end
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_own_drive();
    req = 1'b1;
    tick();
    tests++; if (o_net !== 1'b0) begin fails++; $display("FAIL drive_latency O got %b want 0", o_net); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k <= 7) begin
        tests++;
        if (FALL !== (k == 5)) begin fails++; $display("FAIL own_fall k=%0d got %b want %b", k, FALL, k == 5); end
      end
    end
    req = 1'b0;
    tick();
    tests++; if (o_net !== 1'b1) begin fails++; $display("FAIL release_latency O got %b want 1", o_net); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests++;
      if (RISE !== (k == 5)) begin fails++; $display("FAIL own_rise k=%0d got %b want %b", k, RISE, k == 5); end
    end
    tick();
    tests++;
    if ({LINE, EXT, STUCK} !== 3'b100) begin
      fails++; $display("FAIL own_idle {LINE,EXT,STUCK} got %b want 100", {LINE, EXT, STUCK});
    end
  endtask

  task automatic test_glitch();
    ext_low = 1'b1;
    repeat (2) tick();
    ext_low = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      tests++;
      if (FALL !== 1'b0 || LINE !== 1'b1) begin
        fails++; $display("FAIL glitch k=%0d FALL/LINE got %b%b want 01", k, FALL, LINE);
      end
    end
  endtask

  task automatic test_ext_holder();
    ext_low = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 4) begin
        tests++;
        if (FALL !== 1'b1 || EXT !== 1'b0) begin
          fails++; $display("FAIL ext_fall FALL/EXT got %b%b want 10", FALL, EXT);
        end
      end
      if (k == 5) begin
        tests++; if (EXT !== 1'b1) begin fails++; $display("FAIL ext_after_fall got %b want 1", EXT); end
      end
    end
    ext_low = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 4) begin
        tests++; if (RISE !== 1'b1) begin fails++; $display("FAIL ext_rise got %b want 1", RISE); end
      end
    end
    tests++;
    if (EXT !== 1'b0 || STUCK !== 1'b0) begin
      fails++; $display("FAIL ext_done EXT/STUCK got %b%b want 00", EXT, STUCK);
    end
  endtask

  task automatic test_stuck();
    req = 1'b1;
    repeat (8) tick();
    ext_low = 1'b1;
    req = 1'b0;
    tick();
    for (int k = 1; k <= RISE_TIMEOUT; k++) begin
      tick();
      tests++;
      if ({STUCK, EXT} !== {2{STUCK_EN && k == RISE_TIMEOUT}}) begin
        fails++; $display("FAIL stuck_timing k=%0d STUCK/EXT got %b%b", k, STUCK, EXT);
      end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests++; if (STUCK !== 1'b0) begin fails++; $display("FAIL stuck_clear got %b want 0", STUCK); end
    req = 1'b1;
    repeat (2) tick();
    req = 1'b0;
    clr = 1'b1;
    repeat (RISE_TIMEOUT + 1) tick();
    clr = 1'b0;
    tests++;
    if (STUCK !== STUCK_EN) begin
      fails++; $display("FAIL stuck_set_beats_clear got %b want %b", STUCK, STUCK_EN);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ext_low = 1'b0;
    repeat (8) tick();
    tests++;
    if ({LINE, EXT, STUCK} !== 3'b100) begin
      fails++; $display("FAIL stuck_recover {LINE,EXT,STUCK} got %b want 100", {LINE, EXT, STUCK});
    end
  endtask

  task automatic test_reassert();
    req = 1'b1;
    repeat (8) tick();
    req = 1'b0;
    repeat (2) tick();
    // Back in before three released samples accumulate, so LINE never sees a rise.
    req = 1'b1;
    for (int k = 0; k < RISE_TIMEOUT + 4; k++) begin
      tick();
      tests++;
      if (RISE !== 1'b0 || STUCK !== 1'b0 || LINE !== 1'b0) begin
        fails++; $display("FAIL reassert k=%0d RISE/STUCK/LINE got %b%b%b want 000", k, RISE, STUCK, LINE);
      end
    end
    tests++; if (o_net !== 1'b0) begin fails++; $display("FAIL reassert_drive O got %b want 0", o_net); end
    req = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid_drive();
    req = 1'b1;
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    req = 1'b0;
    model_reset();
    #1;
    tests++; if (o_net !== 1'b1) begin fails++; $display("FAIL async_release O got %b want 1", o_net); end
    tests++;
    if ({LINE, FALL, RISE, EXT, STUCK} !== 5'b10000) begin
      fails++; $display("FAIL async_outputs got %b want 10000", {LINE, FALL, RISE, EXT, STUCK});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) req = ~req;
      if ($urandom_range(0, 9) == 0) ext_low = ~ext_low;
      clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    req = 1'b0; ext_low = 1'b0; clr = 1'b1;
    repeat (RISE_TIMEOUT + 8) tick();
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_own_drive();
    test_glitch();
    test_ext_holder();
    test_stuck();
    test_reassert();
    test_random();
    test_reset_mid_drive();
    test_own_drive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
